// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port integer register file.
//   XLEN_DEF    : default data width
//   ZERO_REG    : index of the hardwired-zero register
//   addr_width  : register-index width for a given register count
//   cnt_width   : pending-counter width for a given maximum count
//   port_lsb    : low bit of port p inside a packed multi-port bus
package reg_file_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ZERO_REG = 0;

    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    function automatic int cnt_width(input int max_pend);
        return $clog2(max_pend + 1);
    endfunction

    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
// Carries clock enable, packed read ports, packed write ports, issue request,
// scoreboard status and the debug read port. Clock and reset stay outside.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = addr_width(NREGS)
);
    logic                 i_clk_enable;
    logic [NRD*AW-1:0]    i_rd_addr;
    logic [NRD*XLEN-1:0]  o_rd_data;
    logic [NRD-1:0]       o_rd_busy;
    logic [NWR-1:0]       i_wr_en;
    logic [NWR-1:0]       i_wr_retire;
    logic [NWR*AW-1:0]    i_wr_addr;
    logic [NWR*XLEN-1:0]  i_wr_data;
    logic                 i_issue_en;
    logic [AW-1:0]        i_issue_addr;
    logic                 o_issue_stall;
    logic                 o_sb_err;
    logic [AW-1:0]        i_dbg_addr;
    logic [XLEN-1:0]      o_dbg_data;

    modport master (
        output i_clk_enable, i_rd_addr, i_wr_en, i_wr_retire, i_wr_addr,
               i_wr_data, i_issue_en, i_issue_addr, i_dbg_addr,
        input  o_rd_data, o_rd_busy, o_issue_stall, o_sb_err, o_dbg_data
    );

    modport slave (
        input  i_clk_enable, i_rd_addr, i_wr_en, i_wr_retire, i_wr_addr,
               i_wr_data, i_issue_en, i_issue_addr, i_dbg_addr,
        output o_rd_data, o_rd_busy, o_issue_stall, o_sb_err, o_dbg_data
    );

endinterface

// File: rtl/reg_file_mp_pend_counter.sv
// Per-register pending-write counter (scoreboard entry).
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_en         : global clock enable; counter holds when low
//   i_inc        : one more write outstanding (caller guarantees not full)
//   i_dec        : one outstanding write retires
//   o_cnt        : current count
//   o_err        : retire seen while the counter is already zero
module rf_pend_counter
    import reg_file_pkg::*;
#(
    parameter int MAX_PEND = 3,
    parameter int CW       = cnt_width(MAX_PEND)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic          o_err
);
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // Simultaneous inc and dec cancel out; both ends saturate.
    always_comb begin
        cnt_next = cnt_reg;
        if (i_inc && !i_dec && cnt_reg != CW'(MAX_PEND)) begin
            cnt_next = cnt_reg + CW'(1);
        end else if (i_dec && !i_inc && cnt_reg != '0) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_reg <= '0;
        end else if (i_en) begin
            cnt_reg <= cnt_next;
        end
    end

    assign o_cnt = cnt_reg;
    assign o_err = i_en && i_dec && (cnt_reg == '0);

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write bypass and pending-write
// scoreboard.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   rf (slave)   : NRD combinational read ports with busy flags, NWR write
//                  ports (highest index wins), issue/stall handshake,
//                  sticky scoreboard error, raw debug read port
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int MAX_PEND = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    reg_file_mp_if.slave  rf
);
    localparam int AW = addr_width(NREGS);
    localparam int CW = cnt_width(MAX_PEND);

    logic [XLEN-1:0] mem_reg [NREGS];
    logic [CW-1:0]   cnt     [NREGS];
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;
    logic [NREGS-1:0] multi_dec;
    logic [NREGS-1:0] err_req;
    logic             sb_err_reg;
    logic             issue_stall;

    // Register array. Later ports overwrite earlier ones in the loop, which
    // gives the highest-index port priority on an address collision.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (rf.i_clk_enable) begin
            for (int w = 0; w < NWR; w++) begin
                if (rf.i_wr_en[w] && rf.i_wr_addr[port_lsb(w, AW) +: AW] != AW'(ZERO_REG)) begin
                    mem_reg[rf.i_wr_addr[port_lsb(w, AW) +: AW]] <=
                        rf.i_wr_data[port_lsb(w, XLEN) +: XLEN];
                end
            end
        end
    end

    assign issue_stall = rf.i_issue_en && rf.i_issue_addr != AW'(ZERO_REG) &&
                         cnt[rf.i_issue_addr] == CW'(MAX_PEND);

    always_comb begin
        inc = '0;
        if (rf.i_issue_en && !issue_stall && rf.i_issue_addr != AW'(ZERO_REG)) begin
            inc[rf.i_issue_addr] = 1'b1;
        end
    end

    // Retire decode: several ports retiring the same register collapse into
    // one decrement and are flagged as a scoreboard error.
    always_comb begin
        logic [AW-1:0] wa;
        wa        = '0;
        dec       = '0;
        multi_dec = '0;
        for (int w = 0; w < NWR; w++) begin
            wa = rf.i_wr_addr[port_lsb(w, AW) +: AW];
            if (rf.i_wr_en[w] && rf.i_wr_retire[w] && wa != AW'(ZERO_REG)) begin
                multi_dec[wa] = multi_dec[wa] | dec[wa];
                dec[wa]       = 1'b1;
            end
        end
    end

    // Register 0 never sees inc/dec, so its counter stays at zero.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
        rf_pend_counter #(
            .MAX_PEND (MAX_PEND),
            .CW       (CW)
        ) u_cnt (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (rf.i_clk_enable),
            .i_inc (inc[gi]),
            .i_dec (dec[gi]),
            .o_cnt (cnt[gi]),
            .o_err (err_req[gi])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sb_err_reg <= 1'b0;
        end else if (rf.i_clk_enable && ((|err_req) || (|multi_dec))) begin
            sb_err_reg <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;
        logic            retiring;

        assign ra = rf.i_rd_addr[port_lsb(gi, AW) +: AW];

        // Ascending scan so the highest-index matching port supplies data.
        always_comb begin
            byp_hit  = 1'b0;
            byp_data = '0;
            for (int w = 0; w < NWR; w++) begin
                if (rf.i_wr_en[w] && rf.i_wr_addr[port_lsb(w, AW) +: AW] == ra) begin
                    byp_hit  = 1'b1;
                    byp_data = rf.i_wr_data[port_lsb(w, XLEN) +: XLEN];
                end
            end
        end

        assign retiring = rf.i_clk_enable && dec[ra];

        assign rf.o_rd_data[port_lsb(gi, XLEN) +: XLEN] =
            (ra == AW'(ZERO_REG))                        ? '0       :
            (BYPASS != 0 && rf.i_clk_enable && byp_hit) ? byp_data :
                                                           mem_reg[ra];

        // A last outstanding write that retires this cycle is already
        // resolved when its data is bypassed.
        assign rf.o_rd_busy[gi] = (cnt[ra] != '0) &&
            !(BYPASS != 0 && retiring && cnt[ra] == CW'(1));
    end

    assign rf.o_issue_stall = issue_stall;
    assign rf.o_sb_err      = sb_err_reg;
    assign rf.o_dbg_data    = mem_reg[rf.i_dbg_addr];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one instance with bypass, one without,
// driven by the same stimulus. Inputs change on the falling edge and
// outputs are sampled 1 ns later.
module tb_reg_file_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                ce;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_en;
    logic [NWR-1:0]      wr_retire;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;
    logic [AW-1:0]       dbg_addr;

    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_b ();
    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_n ();

    assign bus_b.i_clk_enable = ce;
    assign bus_b.i_rd_addr    = rd_addr;
    assign bus_b.i_wr_en      = wr_en;
    assign bus_b.i_wr_retire  = wr_retire;
    assign bus_b.i_wr_addr    = wr_addr;
    assign bus_b.i_wr_data    = wr_data;
    assign bus_b.i_issue_en   = issue_en;
    assign bus_b.i_issue_addr = issue_addr;
    assign bus_b.i_dbg_addr   = dbg_addr;

    assign bus_n.i_clk_enable = ce;
    assign bus_n.i_rd_addr    = rd_addr;
    assign bus_n.i_wr_en      = wr_en;
    assign bus_n.i_wr_retire  = wr_retire;
    assign bus_n.i_wr_addr    = wr_addr;
    assign bus_n.i_wr_data    = wr_data;
    assign bus_n.i_issue_en   = issue_en;
    assign bus_n.i_issue_addr = issue_addr;
    assign bus_n.i_dbg_addr   = dbg_addr;

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .MAX_PEND(3)
    ) u_byp (
        .i_clk (clk),
        .i_rst (rst),
        .rf    (bus_b)
    );

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .MAX_PEND(3)
    ) u_nob (
        .i_clk (clk),
        .i_rst (rst),
        .rf    (bus_n)
    );

    logic [XLEN-1:0] b_rd0, b_rd1, n_rd0, n_rd1;
    assign b_rd0 = bus_b.o_rd_data[XLEN-1:0];
    assign b_rd1 = bus_b.o_rd_data[2*XLEN-1:XLEN];
    assign n_rd0 = bus_n.o_rd_data[XLEN-1:0];
    assign n_rd1 = bus_n.o_rd_data[2*XLEN-1:XLEN];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic idle();
        wr_en      = '0;
        wr_retire  = '0;
        wr_addr    = '0;
        wr_data    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
    endtask

    task automatic set_wr(input int p, input logic ret, input logic [AW-1:0] a,
                          input logic [XLEN-1:0] d);
        wr_en[p]                  = 1'b1;
        wr_retire[p]              = ret;
        wr_addr[p*AW +: AW]       = a;
        wr_data[p*XLEN +: XLEN]   = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        issue_en   = 1'b1;
        issue_addr = a;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst      = 1'b1;
        ce       = 1'b1;
        rd_addr  = '0;
        dbg_addr = '0;
        idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd7);
        #3;
        check("rst_rd0",    b_rd0, 0);
        check("rst_busy",   bus_b.o_rd_busy, 0);
        check("rst_stall",  bus_b.o_issue_stall, 0);
        check("rst_sberr",  bus_b.o_sb_err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Two ports write x5 in one cycle: port 1 wins.
        idle();
        set_wr(0, 1'b0, 5'd5, 32'h0000_00AA);
        set_wr(1, 1'b0, 5'd5, 32'h0000_00BB);
        set_rd(0, 5'd5);
        #1;
        check("x5_bypass_same",   b_rd0, 32'hBB);
        check("x5_nobypass_same", n_rd0, 32'h0);
        step();
        idle();
        dbg_addr = 5'd5;
        #1;
        check("x5_byp_next", b_rd0, 32'hBB);
        check("x5_nob_next", n_rd0, 32'hBB);
        check("x5_dbg",      bus_n.o_dbg_data, 32'hBB);

        // Register 0 ignores writes and issues.
        set_wr(0, 1'b0, 5'd0, 32'hFFFF_FFFF);
        issue(5'd0);
        set_rd(1, 5'd0);
        #1;
        check("x0_byp_same", b_rd1, 0);
        check("x0_stall",    bus_b.o_issue_stall, 0);
        step();
        idle();
        dbg_addr = 5'd0;
        #1;
        check("x0_rd_next", b_rd1, 0);
        check("x0_busy",    bus_b.o_rd_busy[1], 0);
        check("x0_dbg",     bus_b.o_dbg_data, 0);

        // Scoreboard on x7.
        set_rd(0, 5'd7);
        issue(5'd7);
        #1;
        check("x7_busy_same_issue", bus_b.o_rd_busy[0], 0);
        check("x7_stall_c0",        bus_b.o_issue_stall, 0);
        step();                                 // cnt 1
        #1;
        check("x7_busy_c1", bus_b.o_rd_busy[0], 1);
        step();                                 // cnt 2
        idle();
        issue(5'd7);
        set_wr(0, 1'b1, 5'd7, 32'h77);
        #1;
        check("x7_stall_c2_incdec", bus_b.o_issue_stall, 0);
        step();                                 // inc+dec: cnt stays 2
        idle();
        issue(5'd7);
        #1;
        check("x7_stall_after_incdec", bus_b.o_issue_stall, 0);
        step();                                 // cnt 3
        #1;
        check("x7_stall_c3",   bus_b.o_issue_stall, 1);
        check("x7_stall_c3_n", bus_n.o_issue_stall, 1);
        step();                                 // stalled: cnt stays 3
        #1;
        check("x7_stall_hold", bus_b.o_issue_stall, 1);
        set_wr(0, 1'b1, 5'd7, 32'h78);
        step();                                 // issue stalled, retire: cnt 2
        idle();
        issue(5'd7);
        #1;
        check("x7_stall_after_ret", bus_b.o_issue_stall, 0);
        issue_en = 1'b0;
        set_wr(1, 1'b1, 5'd7, 32'h79);
        #1;
        check("x7_busy_c2_ret", bus_b.o_rd_busy[0], 1);
        step();                                 // cnt 1
        idle();
        set_wr(1, 1'b1, 5'd7, 32'h7A);
        #1;
        check("x7_busy_c1_ret_byp", bus_b.o_rd_busy[0], 0);
        check("x7_busy_c1_ret_nob", bus_n.o_rd_busy[0], 1);
        step();                                 // cnt 0
        idle();
        #1;
        check("x7_busy_c0_b", bus_b.o_rd_busy[0], 0);
        check("x7_busy_c0_n", bus_n.o_rd_busy[0], 0);
        check("x7_data",      n_rd0, 32'h7A);
        check("x7_sberr",     bus_b.o_sb_err, 0);

        // x9: one pending write, retired while being read.
        set_wr(0, 1'b0, 5'd9, 32'hDEAD);
        issue(5'd9);
        step();
        idle();
        set_wr(1, 1'b1, 5'd9, 32'h1234);
        set_rd(1, 5'd9);
        #1;
        check("x9_byp_busy", bus_b.o_rd_busy[1], 0);
        check("x9_byp_data", b_rd1, 32'h1234);
        check("x9_nob_busy", bus_n.o_rd_busy[1], 1);
        check("x9_nob_data", n_rd1, 32'hDEAD);
        step();
        idle();
        #1;
        check("x9_nob_next_data", n_rd1, 32'h1234);
        check("x9_nob_next_busy", bus_n.o_rd_busy[1], 0);

        // Retire at zero: sticky error.
        set_wr(0, 1'b1, 5'd3, 32'h33);
        #1;
        check("x3_sberr_before_edge", bus_b.o_sb_err, 0);
        step();
        idle();
        #1;
        check("x3_sberr_set", bus_b.o_sb_err, 1);
        repeat (10) step();
        #1;
        check("x3_sberr_held_b", bus_b.o_sb_err, 1);
        check("x3_sberr_held_n", bus_n.o_sb_err, 1);

        // Clock enable low: nothing changes, no bypass.
        ce = 1'b0;
        set_wr(0, 1'b0, 5'd4, 32'h55);
        issue(5'd4);
        set_rd(0, 5'd4);
        dbg_addr = 5'd4;
        #1;
        check("ce0_no_bypass", b_rd0, 0);
        step();
        #1;
        check("ce0_dbg",  bus_b.o_dbg_data, 0);
        check("ce0_busy", bus_b.o_rd_busy[0], 0);
        ce = 1'b1;
        idle();
        #1;
        check("ce0_rd_after", b_rd0, 0);

        // Asynchronous reset mid-cycle.
        issue(5'd10);
        step();
        idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd10);
        dbg_addr = 5'd5;
        #1;
        check("pre_rst_rd0",   b_rd0, 32'hBB);
        check("pre_rst_busy1", bus_b.o_rd_busy[1], 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_rd_b",    bus_b.o_rd_data, 0);
        check("arst_rd_n",    bus_n.o_rd_data, 0);
        check("arst_busy",    bus_b.o_rd_busy, 0);
        check("arst_sberr",   bus_b.o_sb_err, 0);
        check("arst_dbg",     bus_n.o_dbg_data, 0);
        check("arst_stall",   bus_b.o_issue_stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
